// File: rtl/jelly_axi4l_to_wishbone_arb.sv
// AXI4-Lite slave to classic Wishbone master bridge with independent AW/W/AR holding registers,
// alternating read/write arbitration, err_i mapped to SLVERR and a programmable stb timeout.
module jelly_axi4l_to_wishbone_arb #(
  parameter int AXI4L_ADDR_WIDTH = 32,
  parameter int AXI4L_DATA_SIZE  = 2,
  parameter int AXI4L_DATA_WIDTH = (8 << AXI4L_DATA_SIZE),
  parameter int AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH / 8,
  parameter int WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - AXI4L_DATA_SIZE,
  parameter int WB_DAT_WIDTH     = AXI4L_DATA_WIDTH,
  parameter int WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT_CYCLES   = 256,
  parameter int TIMEOUT_WIDTH    = 9
) (
  input  logic                        s_axi4l_aresetn,
  input  logic                        s_axi4l_aclk,
  input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_awaddr,
  input  logic [2:0]                  s_axi4l_awprot,
  input  logic                        s_axi4l_awvalid,
  output logic                        s_axi4l_awready,
  input  logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_wdata,
  input  logic [AXI4L_STRB_WIDTH-1:0] s_axi4l_wstrb,
  input  logic                        s_axi4l_wvalid,
  output logic                        s_axi4l_wready,
  output logic [1:0]                  s_axi4l_bresp,
  output logic                        s_axi4l_bvalid,
  input  logic                        s_axi4l_bready,
  input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_araddr,
  input  logic [2:0]                  s_axi4l_arprot,
  input  logic                        s_axi4l_arvalid,
  output logic                        s_axi4l_arready,
  output logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_rdata,
  output logic [1:0]                  s_axi4l_rresp,
  output logic                        s_axi4l_rvalid,
  input  logic                        s_axi4l_rready,
  output logic                        m_wb_rst_o,
  output logic                        m_wb_clk_o,
  output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i,
  output logic                        m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o,
  output logic                        m_wb_stb_o,
  input  logic                        m_wb_ack_i,
  input  logic                        m_wb_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB_ACC = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam bit         TO_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t                      state_q, state_d;
  logic                        prio_rd_q, prio_rd_d;
  logic [TIMEOUT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                        aw_full_q, aw_full_d;
  logic [WB_ADR_WIDTH-1:0]     aw_adr_q, aw_adr_d;
  logic                        w_full_q, w_full_d;
  logic [AXI4L_DATA_WIDTH-1:0] w_dat_q, w_dat_d;
  logic [AXI4L_STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                        ar_full_q, ar_full_d;
  logic [WB_ADR_WIDTH-1:0]     ar_adr_q, ar_adr_d;

  logic                        stb_q, stb_d;
  logic                        we_q, we_d;
  logic [WB_ADR_WIDTH-1:0]     adr_q, adr_d;
  logic [WB_SEL_WIDTH-1:0]     sel_q, sel_d;
  logic [WB_DAT_WIDTH-1:0]     dat_q, dat_d;

  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        rvalid_q, rvalid_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic [AXI4L_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic wr_pend, rd_pend, grant_ok, sel_rd, resp_done, acc_done, acc_ok;

  // prot carries no meaning for a Wishbone target; low address bits are byte offsets.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi4l_awprot, s_axi4l_arprot, s_axi4l_awaddr, s_axi4l_araddr};

  assign wr_pend   = aw_full_q & w_full_q;
  assign rd_pend   = ar_full_q;
  assign resp_done = (bvalid_q & s_axi4l_bready) | (rvalid_q & s_axi4l_rready);

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    cnt_d     = cnt_q;
    aw_full_d = aw_full_q;
    aw_adr_d  = aw_adr_q;
    w_full_d  = w_full_q;
    w_dat_d   = w_dat_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_adr_d  = ar_adr_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    grant_ok  = 1'b0;
    sel_rd    = 1'b0;
    acc_done  = 1'b0;
    acc_ok    = 1'b0;

    if (s_axi4l_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_adr_d  = s_axi4l_awaddr[AXI4L_ADDR_WIDTH-1:AXI4L_DATA_SIZE];
    end
    if (s_axi4l_wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_dat_d  = s_axi4l_wdata;
      w_strb_d = s_axi4l_wstrb;
    end
    if (s_axi4l_arvalid && !ar_full_q) begin
      ar_full_d = 1'b1;
      ar_adr_d  = s_axi4l_araddr[AXI4L_ADDR_WIDTH-1:AXI4L_DATA_SIZE];
    end

    case (state_q)
      ST_IDLE: begin
        grant_ok = 1'b1;
      end
      ST_WB_ACC: begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        // err wins over a simultaneous ack
        if (m_wb_err_i) begin
          acc_done = 1'b1;
        end else if (m_wb_ack_i) begin
          acc_done = 1'b1;
          acc_ok   = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          acc_done = 1'b1;
        end
        if (acc_done) begin
          stb_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RESP;
          if (we_q) begin
            bvalid_d = 1'b1;
            bresp_d  = acc_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = acc_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = acc_ok ? m_wb_dat_i : '0;
          end
        end
      end
      ST_RESP: begin
        if (resp_done) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
          grant_ok = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A grant may coincide with the response handshake that returns to idle.
    if (grant_ok && (wr_pend || rd_pend)) begin
      sel_rd    = rd_pend && (!wr_pend || prio_rd_q);
      prio_rd_d = !sel_rd;
      stb_d     = 1'b1;
      cnt_d     = '0;
      dat_d     = w_dat_q;
      state_d   = ST_WB_ACC;
      if (sel_rd) begin
        adr_d     = ar_adr_q;
        we_d      = 1'b0;
        sel_d     = '1;
        ar_full_d = 1'b0;
      end else begin
        adr_d     = aw_adr_q;
        we_d      = 1'b1;
        sel_d     = w_strb_q;
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
    if (!s_axi4l_aresetn) begin
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b1;
      cnt_q     <= '0;
      aw_full_q <= 1'b0;
      aw_adr_q  <= '0;
      w_full_q  <= 1'b0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_adr_q  <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      cnt_q     <= cnt_d;
      aw_full_q <= aw_full_d;
      aw_adr_q  <= aw_adr_d;
      w_full_q  <= w_full_d;
      w_dat_q   <= w_dat_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_adr_q  <= ar_adr_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi4l_awready = ~aw_full_q;
  assign s_axi4l_wready  = ~w_full_q;
  assign s_axi4l_arready = ~ar_full_q;
  assign s_axi4l_bvalid  = bvalid_q;
  assign s_axi4l_bresp   = bresp_q;
  assign s_axi4l_rvalid  = rvalid_q;
  assign s_axi4l_rresp   = rresp_q;
  assign s_axi4l_rdata   = rdata_q;

  assign m_wb_rst_o = ~s_axi4l_aresetn;
  assign m_wb_clk_o = s_axi4l_aclk;
  assign m_wb_adr_o = adr_q;
  assign m_wb_dat_o = dat_q;
  assign m_wb_we_o  = we_q;
  assign m_wb_sel_o = sel_q;
  assign m_wb_stb_o = stb_q;

endmodule

// File: tb/tb_jelly_axi4l_to_wishbone_arb.sv
// Directed bench for the AXI4-Lite to Wishbone bridge: a vector table of single accesses plus
// sequences for channel skew, arbitration order, timeout, error/backpressure and async reset.
module tb_jelly_axi4l_to_wishbone_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        wb_rst, wb_clk;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb, wb_ack, wb_err;
  logic        ack_en = 1'b1;
  logic        err_en = 1'b0;

  always #5 clk = ~clk;

  assign wb_ack   = ack_en & wb_stb;
  assign wb_err   = err_en & wb_stb;
  assign wb_dat_i = 32'(wb_adr) + 32'd1;

  jelly_axi4l_to_wishbone_arb #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_WIDTH  (9)
  ) dut (
    .s_axi4l_aresetn (rst_n),
    .s_axi4l_aclk    (clk),
    .s_axi4l_awaddr  (awaddr),
    .s_axi4l_awprot  (awprot),
    .s_axi4l_awvalid (awvalid),
    .s_axi4l_awready (awready),
    .s_axi4l_wdata   (wdata),
    .s_axi4l_wstrb   (wstrb),
    .s_axi4l_wvalid  (wvalid),
    .s_axi4l_wready  (wready),
    .s_axi4l_bresp   (bresp),
    .s_axi4l_bvalid  (bvalid),
    .s_axi4l_bready  (bready),
    .s_axi4l_araddr  (araddr),
    .s_axi4l_arprot  (arprot),
    .s_axi4l_arvalid (arvalid),
    .s_axi4l_arready (arready),
    .s_axi4l_rdata   (rdata),
    .s_axi4l_rresp   (rresp),
    .s_axi4l_rvalid  (rvalid),
    .s_axi4l_rready  (rready),
    .m_wb_rst_o      (wb_rst),
    .m_wb_clk_o      (wb_clk),
    .m_wb_adr_o      (wb_adr),
    .m_wb_dat_o      (wb_dat_o),
    .m_wb_dat_i      (wb_dat_i),
    .m_wb_we_o       (wb_we),
    .m_wb_sel_o      (wb_sel),
    .m_wb_stb_o      (wb_stb),
    .m_wb_ack_i      (wb_ack),
    .m_wb_err_i      (wb_err)
  );

  // Wishbone monitor: counts stb-high cycles and logs each access at its first stb cycle.
  int          stb_total = 0;
  int          log_n = 0;
  logic        stb_prev = 1'b0;
  logic        we_log  [64];
  logic [29:0] adr_log [64];
  logic [3:0]  sel_log [64];
  logic [31:0] dat_log [64];

  always @(negedge clk) begin
    if (wb_stb) begin
      stb_total <= stb_total + 1;
      if (!stb_prev && log_n < 64) begin
        we_log[log_n]  <= wb_we;
        adr_log[log_n] <= wb_adr;
        sel_log[log_n] <= wb_sel;
        dat_log[log_n] <= wb_dat_o;
        log_n          <= log_n + 1;
      end
    end
    stb_prev <= wb_stb;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    lat = -1;
    resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 50) begin cyc(); n++; end
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin cyc(); n++; end
    if (!bvalid) tmo("bvalid_wait");
    else begin
      lat = n; resp = bresp;
      bready = 1'b1; cyc(); bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    int n;
    lat = -1;
    resp = 2'b11;
    d = 32'hxxxxxxxx;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin cyc(); n++; end
    cyc();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin cyc(); n++; end
    if (!rvalid) tmo("rvalid_wait");
    else begin
      lat = n; resp = rresp; d = rdata;
      rready = 1'b1; cyc(); rready = 1'b0;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [29:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat, s0, l0, n;
    logic        gb, gr;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 30'h0000_0004, 4'hF, 32'h0000_0005};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 30'h0000_0400, 4'hF, 32'h0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 30'h3FFF_FFFF, 4'hF, 32'h4000_0000};
    vecs[3] = '{1'b1, 32'h0000_0007, 32'hA5A5_A5A5, 4'h8, 30'h0000_0001, 4'h8, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 30'h0000_0000, 4'hF, 32'h0000_0001};
    vecs[5] = '{1'b1, 32'h0000_0084, 32'h0BAD_F00D, 4'h0, 30'h0000_0021, 4'h0, 32'h0};

    // reset values, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_adr_dat_sel", {wb_adr, wb_dat_o, wb_sel}, 0);
    chk("rst_wb_rst", wb_rst, 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // single accesses from the vector table
    for (int i = 0; i < 6; i++) begin
      s0 = stb_total;
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdat, vecs[i].strb, resp, lat);
      else            do_read(vecs[i].addr, rd, resp, lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_stb_cycles", i), stb_total - s0, 1);
      chk($sformatf("v%0d_adr", i), adr_log[log_n-1], vecs[i].exp_adr);
      chk($sformatf("v%0d_we", i), we_log[log_n-1], vecs[i].wr);
      chk($sformatf("v%0d_sel", i), sel_log[log_n-1], vecs[i].exp_sel);
      chk($sformatf("v%0d_resp", i), resp, 2'b00);
      if (vecs[i].wr) chk($sformatf("v%0d_dat_o", i), dat_log[log_n-1], vecs[i].wdat);
      else            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // W arrives three cycles ahead of AW: no grant until both are held
    s0 = stb_total;
    wdata = 32'hDEAD_BEEF; wstrb = 4'h3; wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wfirst_wready_%0d", k), wready, 0);
      chk($sformatf("wfirst_awready_%0d", k), awready, 1);
      cyc();
    end
    chk("wfirst_no_stb", stb_total - s0, 0);
    awaddr = 32'h20; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin cyc(); n++; end
    if (!bvalid) tmo("wfirst_bvalid");
    else begin
      chk("wfirst_latency", n, 2);
      chk("wfirst_bresp", bresp, 2'b00);
      bready = 1'b1; cyc(); bready = 1'b0;
    end
    chk("wfirst_adr", adr_log[log_n-1], 30'h8);
    chk("wfirst_sel", sel_log[log_n-1], 4'h3);
    chk("wfirst_we", we_log[log_n-1], 1);
    chk("wfirst_dat", dat_log[log_n-1], 32'hDEAD_BEEF);

    // simultaneous read and write requests, four rounds
    l0 = log_n;
    for (int r = 0; r < 4; r++) begin
      awaddr = 32'h100 + 32'(r * 8); wdata = 32'(r); wstrb = 4'hF;
      araddr = 32'h200 + 32'(r * 8);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      cyc();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;
      gb = 1'b0; gr = 1'b0; n = 0;
      while (!(gb && gr) && n < 40) begin
        if (bvalid) gb = 1'b1;
        if (rvalid) gr = 1'b1;
        cyc();
        n++;
      end
      bready = 1'b0; rready = 1'b0;
      if (!(gb && gr)) tmo($sformatf("arb_round_%0d", r));
    end
    chk("arb_access_count", log_n - l0, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("arb_order_we_%0d", k), we_log[l0+k], k % 2);

    // hung slave: timeout after 8 stb cycles, then a normal access
    ack_en = 1'b0;
    s0 = stb_total;
    do_read(32'h40, rd, resp, lat);
    chk("to_stb_cycles", stb_total - s0, 8);
    chk("to_latency", lat, 9);
    chk("to_rresp", resp, 2'b10);
    chk("to_rdata", rd, 0);
    ack_en = 1'b1;
    do_read(32'h10, rd, resp, lat);
    chk("after_to_rresp", resp, 2'b00);
    chk("after_to_rdata", rd, 32'h5);

    // err with ack on a write; bready held low while a read waits
    err_en = 1'b1;
    awaddr = 32'h30; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin cyc(); n++; end
    if (!bvalid) tmo("err_bvalid");
    s0 = stb_total;
    araddr = 32'h10; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("err_hold_bvalid_%0d", k), bvalid, 1);
      chk($sformatf("err_hold_bresp_%0d", k), bresp, 2'b10);
      cyc();
    end
    chk("err_hold_no_stb", stb_total - s0, 0);
    err_en = 1'b0;
    bready = 1'b1; cyc(); bready = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin cyc(); n++; end
    if (!rvalid) tmo("err_next_rvalid");
    else begin
      chk("err_next_rresp", rresp, 2'b00);
      chk("err_next_rdata", rdata, 32'h5);
      rready = 1'b1; cyc(); rready = 1'b0;
    end

    // reset asserted while stb is high
    ack_en = 1'b0;
    araddr = 32'h44; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    n = 0;
    while (!wb_stb && n < 20) begin cyc(); n++; end
    if (!wb_stb) tmo("rst_mid_stb");
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rstmid_stb", wb_stb, 0);
    chk("rstmid_bvalid", bvalid, 0);
    chk("rstmid_rvalid", rvalid, 0);
    ack_en = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rstmid_readys", {awready, wready, arready}, 3'b111);
    s0 = stb_total;
    repeat (4) cyc();
    chk("rstmid_no_resp", {bvalid, rvalid}, 2'b00);
    chk("rstmid_no_stb", stb_total - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
